// File: rtl/test_monitor_pkg.sv
// -----------------------------------------------------------------------------
// test_monitor_pkg
// Shared definitions for the result monitor and the board display blocks.
//   state_t : monitor FSM encoding (WAIT=0, PASS=1, FAIL=2, TIMEOUT=3)
//   SEG_OFF : all segments dark (active-low)
//   hex7()  : 4-bit hex nibble to active-low {g,f,e,d,c,b,a} pattern
// -----------------------------------------------------------------------------
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/test_monitor_display.sv
// -----------------------------------------------------------------------------
// hex_display
// Four-digit multiplexed 7-segment driver. A slot counter divides the clock;
// on every slot wrap the digit that is about to be shown is latched into the
// registered an/seg outputs and the digit index advances (3 wraps to 0).
// The display stays dark until the first slot wrap.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   val    in   16-bit value to display, digit 0 = val[3:0]
//   seg    out  segments {g,f,e,d,c,b,a}, active low
//   an     out  digit enables, active low, an[0] = rightmost
// -----------------------------------------------------------------------------
module hex_display
  import test_monitor_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
  localparam logic [SW-1:0] SLOT_ZERO = SW'(0);

  logic [SW-1:0] slot_r;
  logic [1:0]    idx_r;
  logic [6:0]    seg_r;
  logic [3:0]    an_r;
  logic          slot_wrap_s;
  logic [3:0]    nib_s;

  // Slot wrap detection and selection of the nibble for the current digit.
  always_comb begin
    slot_wrap_s = (slot_r == SLOT_LAST);
    case (idx_r)
      2'd0:    nib_s = val[3:0];
      2'd1:    nib_s = val[7:4];
      2'd2:    nib_s = val[11:8];
      2'd3:    nib_s = val[15:12];
      default: nib_s = 4'h0;
    endcase
  end

  // Slot counter, digit index and registered digit/segment outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= SLOT_ZERO;
      idx_r  <= 2'd0;
      seg_r  <= SEG_OFF;
      an_r   <= 4'hF;
    end else if (slot_wrap_s) begin
      slot_r <= SLOT_ZERO;
      idx_r  <= idx_r + 2'd1;
      an_r   <= ~(4'b0001 << idx_r);
      seg_r  <= hex7(nib_s);
    end else begin
      slot_r <= slot_r + SLOT_ONE;
    end
  end

  assign seg = seg_r;
  assign an  = an_r;

endmodule

// File: rtl/test_monitor.sv
// -----------------------------------------------------------------------------
// test_monitor
// Judges each triggered CPU result against EXPECT and keeps a sticky
// WAIT/PASS/FAIL/TIMEOUT status shown on green/red LEDs. Captures the last
// triggered value for the 7-segment display and counts triggers (saturating).
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   temp_out  in   32-bit result, valid while temp_trg = 1
//   temp_trg  in   single-cycle result strobe
//   led_g     out  green LED, active high
//   led_r     out  red LED, active high
//   seg       out  segments {g,f,e,d,c,b,a}, active low
//   an        out  digit enables, active low, an[0] = rightmost
//   trg_cnt   out  triggers seen, saturates at 8'hFF
// -----------------------------------------------------------------------------
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter logic [31:0] EXPECT    = 32'h00004038,
  parameter int          BLINK_DIV = 25_000_000,
  parameter int          SCAN_DIV  = 100_000,
  parameter int          TIMEOUT   = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] temp_out,
  input  logic        temp_trg,
  output logic        led_g,
  output logic        led_r,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [7:0]  trg_cnt
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [TW-1:0] TMO_ZERO   = TW'(0);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [TW-1:0] tmo_cnt_r;
  logic [TW-1:0] tmo_cnt_nxt_s;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_r;
  logic          blink_nxt_s;
  logic          blink_wrap_s;
  logic          match_s;
  logic          led_grn_r;
  logic          led_red_r;
  logic          led_grn_nxt_s;
  logic          led_red_nxt_s;
  // Only the four displayed nibbles of the captured value are ever observed.
  logic [15:0]   last_val_r;
  logic [7:0]    trg_cnt_r;

  // Next-state and timeout-count logic; a trigger always beats timeout expiry.
  always_comb begin
    state_nxt_s   = state_r;
    tmo_cnt_nxt_s = TMO_ZERO;
    match_s       = (temp_out == EXPECT);
    case (state_r)
      ST_WAIT: begin
        if (temp_trg) begin
          state_nxt_s = match_s ? ST_PASS : ST_FAIL;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s = ST_TIMEOUT;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
        end
      end
      ST_PASS: begin
        if (temp_trg && !match_s) begin
          state_nxt_s = ST_FAIL;
        end else begin
          state_nxt_s = ST_PASS;
        end
      end
      ST_FAIL: begin
        state_nxt_s = ST_FAIL;
      end
      ST_TIMEOUT: begin
        if (temp_trg) begin
          state_nxt_s = match_s ? ST_PASS : ST_FAIL;
        end else begin
          state_nxt_s = ST_TIMEOUT;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT;
      end
    endcase
  end

  // Blink phase for the coming cycle and the LED pattern of the next state,
  // so LEDs follow the state with the same one-cycle latency.
  always_comb begin
    blink_wrap_s  = (blink_cnt_r == BLINK_LAST);
    blink_nxt_s   = blink_wrap_s ? ~blink_r : blink_r;
    led_grn_nxt_s = 1'b0;
    led_red_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_WAIT:    led_grn_nxt_s = blink_nxt_s;
      ST_PASS:    led_grn_nxt_s = 1'b1;
      ST_FAIL:    led_red_nxt_s = 1'b1;
      ST_TIMEOUT: led_red_nxt_s = blink_nxt_s;
      default: begin
        led_grn_nxt_s = 1'b0;
        led_red_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_WAIT;
      tmo_cnt_r <= TMO_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end

  // Free-running blink divider, active in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= BLINK_ZERO;
      blink_r     <= 1'b0;
    end else begin
      blink_cnt_r <= blink_wrap_s ? BLINK_ZERO : (blink_cnt_r + BLINK_ONE);
      blink_r     <= blink_nxt_s;
    end
  end

  // Registered LED outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_grn_r <= 1'b0;
      led_red_r <= 1'b0;
    end else begin
      led_grn_r <= led_grn_nxt_s;
      led_red_r <= led_red_nxt_s;
    end
  end

  // Capture of the triggered value and saturating trigger count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val_r <= 16'h0000;
      trg_cnt_r  <= 8'h00;
    end else if (temp_trg) begin
      last_val_r <= temp_out[15:0];
      trg_cnt_r  <= (trg_cnt_r == 8'hFF) ? 8'hFF : (trg_cnt_r + 8'h01);
    end else begin
      last_val_r <= last_val_r;
      trg_cnt_r  <= trg_cnt_r;
    end
  end

  hex_display #(
    .SCAN_DIV (SCAN_DIV)
  ) u_display (
    .clk   (clk),
    .rst_n (rst_n),
    .val   (last_val_r),
    .seg   (seg),
    .an    (an)
  );

  assign led_g   = led_grn_r;
  assign led_r   = led_red_r;
  assign trg_cnt = trg_cnt_r;

endmodule

// File: tb/tb_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_monitor
// Scoreboard bench: the stimulus process updates a status-level reference
// model for every clock and queues the expected outputs; the monitor pops one
// entry after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_test_monitor;

  localparam int          BLINK_DIV = 4;
  localparam int          SCAN_DIV  = 2;
  localparam int          TIMEOUT   = 50;
  localparam logic [31:0] EXPECT    = 32'h00004038;

  localparam int S_WAIT = 0;
  localparam int S_PASS = 1;
  localparam int S_FAIL = 2;
  localparam int S_TMO  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] temp_out = 32'h0;
  logic        temp_trg = 1'b0;
  logic        led_g;
  logic        led_r;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [7:0]  trg_cnt;

  test_monitor #(
    .EXPECT    (EXPECT),
    .BLINK_DIV (BLINK_DIV),
    .SCAN_DIV  (SCAN_DIV),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .temp_out (temp_out),
    .temp_trg (temp_trg),
    .led_g    (led_g),
    .led_r    (led_r),
    .seg      (seg),
    .an       (an),
    .trg_cnt  (trg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       g;
    logic       r;
    logic [6:0] sg;
    logic [3:0] a;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  int          m_cyc;
  int          m_status;
  int          m_idle;
  int          m_cnt;
  logic [31:0] m_last;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc    = 0;
    m_status = S_WAIT;
    m_idle   = 0;
    m_cnt    = 0;
    m_last   = 32'h0;
    m_an     = 4'hF;
    m_seg    = 7'h7F;
  endtask

  // Drive one cycle of input (called at a falling edge), predict the outputs
  // after the next rising edge, queue them, then wait for the next falling edge.
  task automatic step(input logic t, input logic [31:0] v);
    exp_t       e;
    int         digit;
    logic [3:0] nib;
    logic       blink;
    temp_trg = t;
    temp_out = v;
    m_cyc++;
    if (m_cyc % SCAN_DIV == 0) begin
      digit = ((m_cyc / SCAN_DIV) - 1) % 4;
      nib = 4'((m_last >> (4 * digit)) & 32'hF);
      m_an = 4'hF;
      m_an[digit] = 1'b0;
      m_seg = seg_tab[nib];
    end
    if (m_status != S_FAIL) begin
      if (t) begin
        m_status = (v == EXPECT) ? S_PASS : S_FAIL;
      end else if (m_status == S_WAIT) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_status = S_TMO;
      end
    end
    if (t) begin
      m_last = v;
      if (m_cnt < 255) m_cnt++;
    end
    blink = 1'((m_cyc / BLINK_DIV) % 2);
    e.g   = (m_status == S_PASS) || ((m_status == S_WAIT) && blink);
    e.r   = (m_status == S_FAIL) || ((m_status == S_TMO) && blink);
    e.sg  = m_seg;
    e.a   = m_an;
    e.cnt = 8'(m_cnt);
    e.cyc = m_cyc;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom);
  endtask

  // Assert reset between clock edges, check outputs at once, release on a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    temp_trg = 1'b0;
    #1;
    check("rst_led_g", {31'b0, led_g}, 32'h0, -1);
    check("rst_led_r", {31'b0, led_r}, 32'h0, -1);
    check("rst_seg", {25'b0, seg}, 32'h7F, -1);
    check("rst_an", {28'b0, an}, 32'hF, -1);
    check("rst_trg_cnt", {24'b0, trg_cnt}, 32'h0, -1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare one queued expectation just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("led_g", {31'b0, led_g}, {31'b0, e.g}, e.cyc);
        check("led_r", {31'b0, led_r}, {31'b0, e.r}, e.cyc);
        check("seg", {25'b0, seg}, {25'b0, e.sg}, e.cyc);
        check("an", {28'b0, an}, {28'b0, e.a}, e.cyc);
        check("trg_cnt", {24'b0, trg_cnt}, {24'b0, e.cnt}, e.cyc);
      end
    end
  end

  initial begin
    int n;
    int p;
    model_reset();
    @(negedge clk);

    // single pass, then hold
    do_reset();
    step(1'b1, EXPECT);
    idle(6);

    // pass, mismatch, pass again: FAIL is sticky
    do_reset();
    step(1'b1, EXPECT);
    step(1'b0, 32'h0);
    step(1'b1, 32'h00001234);
    step(1'b0, 32'h0);
    step(1'b1, EXPECT);
    idle(6);

    // timeout with blinking red, then a late pass
    do_reset();
    idle(TIMEOUT + 12);
    step(1'b1, EXPECT);
    idle(4);

    // trigger in the very cycle the timeout would expire
    do_reset();
    idle(TIMEOUT - 1);
    step(1'b1, EXPECT);
    idle(4);

    // display scan of 0x4038
    do_reset();
    step(1'b1, EXPECT);
    idle(16);

    // randomized rounds with varying trigger density
    for (int r = 0; r < 10; r++) begin
      do_reset();
      n = $urandom_range(120, 40);
      case (r % 3)
        0:       p = 2;
        1:       p = 10;
        default: p = 40;
      endcase
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(99, 0) < p)
          step(1'b1, ($urandom_range(1, 0) == 0) ? EXPECT : $urandom);
        else
          step(1'b0, $urandom);
      end
    end

    // counter saturation, then asynchronous reset mid-blink
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, ($urandom_range(3, 0) == 0) ? $urandom : EXPECT);
    idle(3);
    do_reset();
    idle(5);

    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
